// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I dmem interface: sized loads/stores, posted write buffer with
// load forwarding, illegal-store tracking. Define DMEM_MMIO_EN to add the GPIO register and cycle counter.
module dmem_responder #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] dmem_rw_addr,
    input  logic [31:0] rs2_data,
    input  logic        dmem_w_en,
    input  logic [2:0]  funct3,
    output logic [31:0] dmem_r_data,
    output logic        store_err,
    output logic [7:0]  err_count
`ifdef DMEM_MMIO_EN
    ,
    output logic [31:0] gpio_out
`endif
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << IDX_W;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [31:0] mem_q [DEPTH];

    logic             wb_valid_q, wb_valid_d;
    logic [IDX_W-1:0] wb_idx_q,   wb_idx_d;
    logic [3:0]       wb_mask_q,  wb_mask_d;
    logic [31:0]      wb_data_q,  wb_data_d;
    logic             store_err_q, store_err_d;
    logic [7:0]       err_count_q, err_count_d;

    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             in_range;

    logic             st_mem_ok;
    logic [3:0]       st_mask;
    logic [31:0]      st_data;
    logic             st_mem;
    logic             st_illegal;
    logic             mmio_wr;

    logic [31:0]      raw;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;

`ifdef DMEM_MMIO_EN
    logic [31:0] gpio_q, gpio_d;
    logic [31:0] cnt_q,  cnt_d;
    logic        is_gpio, is_cnt;

    assign is_gpio = (dmem_rw_addr == 32'hFFFF_FF00);
    assign is_cnt  = (dmem_rw_addr == 32'hFFFF_FF04);
    // Only a full-word store to the GPIO register is legal; the counter address is read-only.
    assign mmio_wr = dmem_w_en && is_gpio && (funct3 == F3_W);
`else
    assign mmio_wr = 1'b0;
`endif

    assign idx      = dmem_rw_addr[ADDR_WIDTH-1:2];
    assign lane     = dmem_rw_addr[1:0];
    assign in_range = (dmem_rw_addr[31:ADDR_WIDTH] == '0);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        st_mem_ok = 1'b0;
        st_mask   = 4'b0000;
        st_data   = rs2_data;
        unique case (funct3)
            F3_B: begin
                st_mem_ok = in_range;
                st_mask   = 4'b0001 << lane;
                st_data   = {4{rs2_data[7:0]}};
            end
            F3_H: begin
                st_mem_ok = in_range && !lane[0];
                st_mask   = 4'b0011 << lane;
                st_data   = {2{rs2_data[15:0]}};
            end
            F3_W: begin
                st_mem_ok = in_range && (lane == 2'b00);
                st_mask   = 4'b1111;
            end
            default: ;
        endcase
    end

    assign st_mem     = dmem_w_en && st_mem_ok;
    assign st_illegal = dmem_w_en && !st_mem_ok && !mmio_wr;

    always_comb begin
        wb_valid_d  = st_mem;
        wb_idx_d    = st_mem ? idx     : wb_idx_q;
        wb_mask_d   = st_mem ? st_mask : wb_mask_q;
        wb_data_d   = st_mem ? st_data : wb_data_q;
        store_err_d = store_err_q | st_illegal;
        err_count_d = err_count_q;
        if (st_illegal && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

`ifdef DMEM_MMIO_EN
    always_comb begin
        gpio_d = mmio_wr ? rs2_data : gpio_q;
        cnt_d  = cnt_q + 32'd1;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid_q  <= 1'b0;
            wb_idx_q    <= '0;
            wb_mask_q   <= 4'b0000;
            wb_data_q   <= 32'h0;
            store_err_q <= 1'b0;
            err_count_q <= 8'h00;
`ifdef DMEM_MMIO_EN
            gpio_q      <= 32'h0;
            cnt_q       <= 32'h0;
`endif
        end else begin
            wb_valid_q  <= wb_valid_d;
            wb_idx_q    <= wb_idx_d;
            wb_mask_q   <= wb_mask_d;
            wb_data_q   <= wb_data_d;
            store_err_q <= store_err_d;
            err_count_q <= err_count_d;
`ifdef DMEM_MMIO_EN
            gpio_q      <= gpio_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    // NOTE: the array has no reset so it maps onto RAM; a pending entry is dropped because reset clears wb_valid_q.
    always_ff @(posedge clock) begin
        if (wb_valid_q) begin
            for (int k = 0; k < 4; k++) begin
                if (wb_mask_q[k]) begin
                    mem_q[wb_idx_q][k*8 +: 8] <= wb_data_q[k*8 +: 8];
                end
            end
        end
    end

    // Forward buffered bytes so a load sees a store in the cycle right after its edge.
    always_comb begin
        raw = mem_q[idx];
        for (int k = 0; k < 4; k++) begin
            if (wb_valid_q && (wb_idx_q == idx) && wb_mask_q[k]) begin
                raw[k*8 +: 8] = wb_data_q[k*8 +: 8];
            end
        end
    end

    assign ld_byte = raw[{lane, 3'b000} +: 8];
    assign ld_half = raw[{lane[1], 4'b0000} +: 16];

    always_comb begin
        dmem_r_data = 32'h0;
        unique case (funct3)
            F3_B:  if (in_range) dmem_r_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU: if (in_range) dmem_r_data = {24'h0, ld_byte};
            F3_H:  if (in_range && !lane[0]) dmem_r_data = {{16{ld_half[15]}}, ld_half};
            F3_HU: if (in_range && !lane[0]) dmem_r_data = {16'h0, ld_half};
            F3_W: begin
                if (in_range && (lane == 2'b00)) dmem_r_data = raw;
`ifdef DMEM_MMIO_EN
                if (is_gpio) dmem_r_data = gpio_q;
                if (is_cnt)  dmem_r_data = cnt_q;
`endif
            end
            default: ;
        endcase
    end

    assign store_err = store_err_q;
    assign err_count = err_count_q;
`ifdef DMEM_MMIO_EN
    assign gpio_out  = gpio_q;
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the single-cycle RV32I core. It is the memory end of the core's dmem interface: address, store data, write enable and funct3 come in; load data goes out.
- Implements RV32I byte, half and word access semantics: lane selection, store masking, and load sign/zero extension.
- Stores go through a one-entry posted write buffer with load forwarding.
- Flags illegal stores with a sticky error bit and a saturating error count.

Parameters:
- ADDR_WIDTH, 12, byte-address width of the backing array. Depth is 2^(ADDR_WIDTH-2) 32-bit words.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- dmem_rw_addr  in  32  byte address of the load or store
- rs2_data  in  32  store data; the low bits are used for SB/SH
- dmem_w_en  in  1  1 = store this cycle
- funct3  in  3  access size and signedness (RV32I encoding)
- dmem_r_data  out  32  extended load data, combinational
- store_err  out  1  sticky illegal-store flag
- err_count  out  8  number of illegal stores, saturating

Behaviour:
- Address decode:
  - idx = addr[ADDR_WIDTH-1:2]; lane = addr[1:0].
  - in_range = (addr[31:ADDR_WIDTH] == 0).
- Store legality, sampled at posedge when dmem_w_en = 1:
  - 000 SB: always aligned. mask = 1 << lane; data = rs2_data[7:0] replicated to all 4 bytes.
  - 001 SH: requires lane[0] = 0. mask = 0011 << lane; data = rs2_data[15:0] replicated to both halves.
  - 010 SW: requires lane = 00. mask = 1111.
  - Any other funct3, any misaligned store, or !in_range: illegal. No write occurs, store_err is set to 1, and err_count increments, saturating at 255.
- Posted write buffer (wb_valid, wb_idx, wb_mask[3:0], wb_data[31:0]):
  - On each posedge, if wb_valid, bytes selected by wb_mask are written to mem[wb_idx].
  - On the same edge a legal store loads the buffer and sets wb_valid = 1. Otherwise wb_valid = 0.
  - Back-to-back stores to the same word are allowed. The old entry drains and the new one is captured on the same edge, with no stall.
- Load path (combinational, 0-cycle latency):
  - raw = mem[idx], with each byte k replaced by wb_data byte k when wb_valid && wb_idx == idx && wb_mask[k].
  - Extraction by funct3:
    - 000 LB: sign-extend the selected byte.
    - 100 LBU: zero-extend the selected byte.
    - 001 LH / 101 LHU: sign- or zero-extend raw[lane*8 +: 16]; requires lane[0] = 0.
    - 010 LW: requires lane = 00.
  - Misaligned, out-of-range or other funct3: dmem_r_data = 0, and the error state is unchanged. The core drives the address on every instruction, so load errors are not tracked.
- Store-to-load visibility: a store at edge N is returned by a load in the cycle after edge N (via forwarding). It is resident in the array after edge N+1.
- Reset (asynchronous, active-low):
  - wb_valid = 0, store_err = 0, err_count = 0.
  - Array contents are not reset and are undefined until written.
  - Reset asserted with a store pending in the buffer: that store is discarded.
  - Reset takes priority over a store on the same edge.

Optional Feature:
- DMEM_MMIO_EN defined:
  - Adds output port gpio_out (32 bits, reset value 0).
  - 32'hFFFF_FF00: SW-only write register driving gpio_out, updated at the store edge with no buffering. Readable via LW.
  - 32'hFFFF_FF04: read-only free-running 32-bit cycle counter. Reset value 0; increments every clock and wraps from FFFF_FFFF to 0. Stores to this address are illegal.
  - SB/SH to either MMIO address: illegal store.
- DMEM_MMIO_EN undefined:
  - No gpio_out port and no counter.
  - Both addresses are out of range: stores are errors, loads return 0.

Test Plan:
- Reset, then SW 0x8000_00F0 to 0x010. The next cycle LW 0x010 returns 0x8000_00F0, through forwarding. Two cycles later it returns the same value from the array.
- SW 0x1122_3344 to 0x020, then SB rs2 = 0xAB to 0x022 in the next cycle. Then:
  - LW 0x020 returns 0x11AB_3344.
  - LB 0x022 returns 0xFFFF_FFAB.
  - LBU 0x022 returns 0x0000_00AB.
- SH 0x8001 to 0x032. LH 0x032 returns 0xFFFF_8001; LHU 0x032 returns 0x0000_8001.
- SH to 0x031, SW to 0x022, SW to 0x0000_1000 (out of range for ADDR_WIDTH = 12), and funct3 = 011 store:
  - store_err = 1 and err_count = 4.
  - Memory is unchanged, including 0x020 and 0x030 read back intact.
  - 300 illegal stores: err_count holds at 255.
- SW to 0x040, with reset_n pulsed low before the drain edge. After reset, wb_valid = 0, store_err = 0, err_count = 0, and LW 0x040 does not return the new data.
- DMEM_MMIO_EN defined:
  - SW 0xDEAD_BEEF to 0xFFFF_FF00: gpio_out = 0xDEAD_BEEF after the edge.
  - Two LW reads of 0xFFFF_FF04 taken 5 cycles apart differ by 5.
  - SB to 0xFFFF_FF00 sets store_err.
